pwm_multi_channel: RTL
======================

Name: pwm_multi_channel

Overview:
- Parametrised multi-channel PWM generator; successor to the single 8-output PWM block in the onboarding peripheral.
- Sits behind the SPI register file and drives uo_out/uio_out. Adds:
  - configurable channel count and counter width;
  - a clock prescaler;
  - a programmable period;
  - double-buffered configuration, applied only at period boundaries so updates never glitch.

Parameters:
- NUM_CH, 8: number of PWM channels (1..16).
- WIDTH, 8: counter, period and duty width in bits (2..16).
- PRESC_W, 8: prescaler register width in bits (1..16).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- cfg_load  in  1  single-cycle strobe; captures all cfg_* inputs into pending registers.
- cfg_prescale  in  PRESC_W  tick divider; tick every cfg_prescale+1 clk cycles.
- cfg_period  in  WIDTH  terminal count P.
- cfg_duty  in  NUM_CH*WIDTH  per-channel duty D[i]; channel i at bits [i*WIDTH +: WIDTH].
- cfg_out_en  in  NUM_CH  per-channel output enable.
- cfg_pwm_en  in  NUM_CH  per-channel mode: 1 = PWM, 0 = static high.
- pwm_out  out  NUM_CH  registered channel outputs.
- period_end  out  1  one-cycle pulse on each period boundary.
- cfg_pending  out  1  high while pending config has not yet been applied.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All active and pending registers go to 0; prescaler counter and period counter cnt go to 0.
  - pwm_out=0, period_end=0, cfg_pending=0.
  - Reset dominates cfg_load in the same cycle. Reset mid-period aborts the period immediately.
- Prescaler:
  - pc counts 0..presc_act.
  - tick=1 in a cycle where pc==presc_act, and pc returns to 0.
  - presc_act=0 gives tick every cycle.
- Counter (edge-aligned), advances on tick only:
  - If cnt==P_act: cnt<=0 and boundary=1.
  - Else cnt<=cnt+1.
  - Period is P_act+1 ticks. P_act=0 gives a boundary every tick.
- Boundary:
  - period_end=1 for exactly the clk cycle after the boundary tick.
  - If cfg_pending=1: all pending regs copy to active regs (prescale, period, duty, out_en, pwm_en), and cfg_pending<=0.
  - New prescale takes effect from the next pc restart.
- cfg_load:
  - Pending <= cfg_* and cfg_pending<=1, one cycle after the strobe.
  - Load coincident with a boundary: active gets the old pending values; pending gets the new values; cfg_pending stays 1.
  - Back-to-back loads: the last load wins.
- Output, registered, 1 clk latency from cnt:
  - pwm_out[i] = out_en_act[i] & (pwm_en_act[i] ? (cnt < D_act[i]) : 1).
  - D=0 gives constant low.
  - D>P gives constant high.
  - High time is D ticks out of P+1. The comparison is unsigned, WIDTH bits.
- After reset all outputs stay low until a cfg_load is applied. With P_act=0 the first load applies at the first tick boundary.
- cnt, pc and D never overflow. If P_act is lowered below cnt, the new value only takes effect at the boundary, so cnt never exceeds P_act.

Optional Feature:
- Macro: PWM_CENTER_ALIGN_EN.
- When defined:
  - Counter runs up-down on ticks: 0,1..P,P-1..1, then 0. Period is 2P ticks.
  - Boundary is the tick where cnt returns to 0. P=0 gives a boundary every tick.
  - Direction flag resets to up.
  - Same compare gives a symmetric pulse of 2D-1 ticks (D in 1..P), centred on cnt=0.
  - D=0 gives low; D>P gives high.
- When undefined: edge-aligned only, with no direction register.

Test Plan:
- Reset, then load P=9, presc=0, D[0]=3, out_en=1, pwm_en=1 → after first boundary:
  - ch0 high 3 / low 7 clk cycles, repeating;
  - period_end pulses every 10 cycles;
  - cfg_pending drops at that boundary.
- presc=3, P=4, D[1]=2 → ch1 high 8 cycles, low 12, period 20 cycles.
- Boundary cases on ch2/ch3/ch4 with P=7:
  - D=0 → constant 0;
  - D=8 → constant 1;
  - pwm_en=0 with out_en=1 → constant 1;
  - out_en=0 → constant 0.
- Mid-period load of D[0]=5 at cnt=4 → current period keeps the old duty; new duty starts exactly at the next boundary with no glitch. A load coincident with a boundary is deferred one more period.
- Assert rst mid-period with outputs high → next cycle all outputs 0, cnt=0, cfg_pending=0, and no output activity until the next load.
- With PWM_CENTER_ALIGN_EN defined, P=4, D=2 → pattern high 3 / low 5 ticks, period 8 ticks, period_end every 8 ticks.

Source files
------------

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM with prescaler, programmable period and boundary-applied config.
// Define PWM_CENTER_ALIGN_EN for an up-down (center-aligned) counter.
module pwm_multi_channel #(
  parameter int NUM_CH  = 8,
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_load,
  input  logic [PRESC_W-1:0]      cfg_prescale,
  input  logic [WIDTH-1:0]        cfg_period,
  input  logic [NUM_CH*WIDTH-1:0] cfg_duty,
  input  logic [NUM_CH-1:0]       cfg_out_en,
  input  logic [NUM_CH-1:0]       cfg_pwm_en,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_end,
  output logic                    cfg_pending
);

  logic [PRESC_W-1:0]      pend_presc;
  logic [PRESC_W-1:0]      presc_act;
  logic [PRESC_W-1:0]      pc;
  logic [WIDTH-1:0]        pend_period;
  logic [WIDTH-1:0]        per_act;
  logic [WIDTH-1:0]        cnt;
  logic [WIDTH-1:0]        cnt_nxt;
  logic [NUM_CH*WIDTH-1:0] pend_duty;
  logic [NUM_CH*WIDTH-1:0] duty_act;
  logic [NUM_CH-1:0]       pend_oe;
  logic [NUM_CH-1:0]       pend_pe;
  logic [NUM_CH-1:0]       oe_act;
  logic [NUM_CH-1:0]       pe_act;
  logic [NUM_CH-1:0]       pwm_nxt;
  logic                    tick;
  logic                    boundary;

  assign tick = (pc == presc_act);

`ifdef PWM_CENTER_ALIGN_EN
  // dir: 0 = counting up, 1 = counting down
  logic dir;
  logic dir_nxt;

  always_comb begin
    cnt_nxt  = cnt;
    dir_nxt  = dir;
    boundary = 1'b0;
    if (tick) begin
      if (!dir) begin
        if (cnt == per_act) begin
          if (per_act == '0) begin
            cnt_nxt  = '0;
            boundary = 1'b1;
          end else begin
            cnt_nxt  = per_act - WIDTH'(1);
            dir_nxt  = (per_act != WIDTH'(1));
            boundary = (per_act == WIDTH'(1));
          end
        end else begin
          cnt_nxt = cnt + WIDTH'(1);
        end
      end else begin
        if (cnt <= WIDTH'(1)) begin
          cnt_nxt  = '0;
          dir_nxt  = 1'b0;
          boundary = 1'b1;
        end else begin
          cnt_nxt = cnt - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir <= 1'b0;
    end else begin
      dir <= dir_nxt;
    end
  end
`else
  always_comb begin
    cnt_nxt  = cnt;
    boundary = 1'b0;
    if (tick) begin
      if (cnt == per_act) begin
        cnt_nxt  = '0;
        boundary = 1'b1;
      end else begin
        cnt_nxt = cnt + WIDTH'(1);
      end
    end
  end
`endif

  always_comb begin
    pwm_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_nxt[i] = oe_act[i] &
        (~pe_act[i] | (cnt < duty_act[i*WIDTH +: WIDTH]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      cnt         <= '0;
      presc_act   <= '0;
      per_act     <= '0;
      duty_act    <= '0;
      oe_act      <= '0;
      pe_act      <= '0;
      pend_presc  <= '0;
      pend_period <= '0;
      pend_duty   <= '0;
      pend_oe     <= '0;
      pend_pe     <= '0;
      cfg_pending <= 1'b0;
      period_end  <= 1'b0;
      pwm_out     <= '0;
    end else begin
      pc         <= tick ? '0 : pc + PRESC_W'(1);
      cnt        <= cnt_nxt;
      period_end <= boundary;
      pwm_out    <= pwm_nxt;
      // active set only changes on the tick that restarts both counters
      if (boundary && cfg_pending) begin
        presc_act <= pend_presc;
        per_act   <= pend_period;
        duty_act  <= pend_duty;
        oe_act    <= pend_oe;
        pe_act    <= pend_pe;
      end
      if (cfg_load) begin
        pend_presc  <= cfg_prescale;
        pend_period <= cfg_period;
        pend_duty   <= cfg_duty;
        pend_oe     <= cfg_out_en;
        pend_pe     <= cfg_pwm_en;
        cfg_pending <= 1'b1;
      end else if (boundary) begin
        cfg_pending <= 1'b0;
      end
    end
  end

endmodule
